sim_run_ctrl: RTL and testbench
===============================

Name: sim_run_ctrl

Overview:
Parametrised run controller for simulation and FPGA bring-up. It sits between the board/bench reset and the CPU core.
- Sequences a programmable-length CPU reset.
- Counts run cycles.
- Detects program end by snooping the core's memory bus for a write to the halt address, capturing the exit code.
- Enforces a cycle-limit watchdog so benches and boards terminate deterministically.

Parameters:
RST_CYCLES, 25, cycles cpu_rst stays high after rst_in falls (legal range ≥1)
MAX_CYCLES, 500, run-cycle limit before timeout; 0 disables the watchdog
CNT_WIDTH, 32, width of the cycle counter
ADDR_WIDTH, 32, width of the snooped address bus
HALT_ADDR, 32'h30004, write to this address ends the program
UART_ADDR, 32'h30000, UART TX data address (used only by the optional feature)

Ports:
clk_in  input  1  system clock; all logic on its rising edge
rst_in  input  1  synchronous active-high reset
mem_a  input  ADDR_WIDTH  core memory address (snooped)
mem_wr  input  1  core write strobe, 1 = write
mem_dout  input  8  core write data byte
cpu_rst  output  1  reset to the CPU core, active-high
running  output  1  high while in RUN
done  output  1  sticky; program wrote HALT_ADDR
timeout  output  1  sticky; watchdog expired
exit_code  output  8  mem_dout captured on the halt write
cycle_cnt  output  CNT_WIDTH  cycles spent in RUN
uart_valid  output  1  optional-feature strobe (0 when feature is compiled out)
uart_byte  output  8  optional-feature data (0 when feature is compiled out)
uart_cnt  output  16  optional-feature byte count (0 when feature is compiled out)

Behaviour:
- rst_in=1 at an edge, including mid-run or after DONE/TIMEOUT:
  - state=RESET, reset counter=0, cpu_rst=1, running=0.
  - done=0, timeout=0, exit_code=0, cycle_cnt=0, uart outputs 0.
- RESET:
  - cpu_rst=1; reset counter increments on each edge with rst_in=0.
  - When the counter reaches RST_CYCLES-1 → RUN. cpu_rst therefore stays high for exactly RST_CYCLES edges after rst_in falls.
- RUN:
  - cpu_rst=0, running=1; cycle_cnt increments by 1 each edge and wraps modulo 2^CNT_WIDTH.
  - Halt: mem_wr=1 and mem_a==HALT_ADDR → next edge: state=DONE, done=1, exit_code=mem_dout. The halt cycle itself is counted.
  - Watchdog: MAX_CYCLES≠0 and cycle_cnt==MAX_CYCLES-1 at the edge with no halt → TIMEOUT, timeout=1, cycle_cnt=MAX_CYCLES.
  - Simultaneous halt and watchdog expiry: halt wins; done=1, timeout stays 0.
  - Writes to HALT_ADDR with mem_wr=0 (reads) are ignored.
- DONE / TIMEOUT:
  - Terminal. cpu_rst=1 (core frozen), running=0; cycle_cnt and exit_code hold.
  - Further bus activity is ignored. Only rst_in exits.
- All outputs are registered; no combinational path from inputs to outputs.
- Address compare uses all ADDR_WIDTH bits.

Optional Feature:
Macro SIM_RUN_CTRL_UART_TAP_EN.
- Defined:
  - In RUN, mem_wr=1 and mem_a==UART_ADDR → next edge uart_valid=1 for exactly one cycle, uart_byte=mem_dout, uart_cnt+=1 (saturates at 16'hFFFF).
  - uart_byte holds its value between strobes.
- Undefined: uart_valid, uart_byte and uart_cnt are constant 0; no UART compare logic is present.

Test Plan:
1. rst_in high 3 cycles then low → cpu_rst high for exactly 25 further edges, falls on edge 25, running=1; cycle_cnt=0 on the first RUN cycle.
2. Run 40 cycles, then write 8'h2A to 32'h30004 → done=1 next edge, exit_code=8'h2A, cycle_cnt=41 and frozen, cpu_rst=1.
3. No halt, MAX_CYCLES=500 → timeout=1 after 500 RUN cycles, cycle_cnt=500, done=0. With MAX_CYCLES=0 and 2000 cycles → timeout never asserts.
4. Halt write on the cycle the watchdog would expire (MAX_CYCLES=10, write on RUN cycle 10) → done=1, timeout=0.
5. Assert rst_in in DONE and again mid-RUN → all outputs return to reset values and the RST_CYCLES sequence restarts. A read (mem_wr=0) of 32'h30004 → no halt.
6. With SIM_RUN_CTRL_UART_TAP_EN, write 'H','i' to 32'h30000 → two single-cycle uart_valid pulses with uart_byte 8'h48, 8'h69 and uart_cnt=2. Without the macro → uart outputs stay 0.

Source files
------------

// File: rtl/sim_run_ctrl.sv
// sim_run_ctrl: run controller placed between the bench/board reset and a CPU core.
// Sequences a fixed-length CPU reset, counts run cycles, detects program end by
// snooping the core bus for a write to HALT_ADDR (capturing the exit code), and
// enforces a cycle-limit watchdog.
// Optional UART TX tap enabled by defining SIM_RUN_CTRL_UART_TAP_EN.
module sim_run_ctrl #(
    parameter int unsigned RST_CYCLES = 25,
    parameter int unsigned MAX_CYCLES = 500,
    parameter int unsigned CNT_WIDTH  = 32,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] HALT_ADDR = ADDR_WIDTH'(32'h30004),
    parameter logic [ADDR_WIDTH-1:0] UART_ADDR = ADDR_WIDTH'(32'h30000)
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic [ADDR_WIDTH-1:0] mem_a,
    input  logic                  mem_wr,
    input  logic [7:0]            mem_dout,
    output logic                  cpu_rst,
    output logic                  running,
    output logic                  done,
    output logic                  timeout,
    output logic [7:0]            exit_code,
    output logic [CNT_WIDTH-1:0]  cycle_cnt,
    output logic                  uart_valid,
    output logic [7:0]            uart_byte,
    output logic [15:0]           uart_cnt
);

    localparam int unsigned RCNT_WIDTH = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [RCNT_WIDTH-1:0] RCNT_LAST = RCNT_WIDTH'(RST_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0]  WDOG_LAST = CNT_WIDTH'(MAX_CYCLES - 1);
    localparam logic                  WDOG_EN   = (MAX_CYCLES != 0);

    typedef enum logic [1:0] {
        S_RESET   = 2'd0,
        S_RUN     = 2'd1,
        S_DONE    = 2'd2,
        S_TIMEOUT = 2'd3
    } state_t;

    state_t                state;
    logic [RCNT_WIDTH-1:0] rcnt;
    logic                  halt_hit_c;
    logic                  wdog_hit_c;

    // Bus snoop and watchdog expiry terms; full-width address compare.
    assign halt_hit_c = mem_wr && (mem_a == HALT_ADDR);
    assign wdog_hit_c = WDOG_EN && (cycle_cnt == WDOG_LAST);

    // Run-control state machine with registered outputs.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state     <= S_RESET;
            rcnt      <= '0;
            cpu_rst   <= 1'b1;
            running   <= 1'b0;
            done      <= 1'b0;
            timeout   <= 1'b0;
            exit_code <= '0;
            cycle_cnt <= '0;
        end else begin
            case (state)
                S_RESET: begin
                    cpu_rst <= 1'b1;
                    running <= 1'b0;
                    if (rcnt == RCNT_LAST) begin
                        state   <= S_RUN;
                        cpu_rst <= 1'b0;
                        running <= 1'b1;
                    end else begin
                        rcnt <= rcnt + RCNT_WIDTH'(1);
                    end
                end
                S_RUN: begin
                    // The halt cycle is itself counted; halt takes priority over expiry.
                    cycle_cnt <= cycle_cnt + CNT_WIDTH'(1);
                    if (halt_hit_c) begin
                        state     <= S_DONE;
                        done      <= 1'b1;
                        exit_code <= mem_dout;
                        cpu_rst   <= 1'b1;
                        running   <= 1'b0;
                    end else if (wdog_hit_c) begin
                        state   <= S_TIMEOUT;
                        timeout <= 1'b1;
                        cpu_rst <= 1'b1;
                        running <= 1'b0;
                    end
                end
                S_DONE, S_TIMEOUT: begin
                    // Terminal: core held in reset until rst_in.
                    cpu_rst <= 1'b1;
                    running <= 1'b0;
                end
                default: begin
                    state   <= S_RESET;
                    rcnt    <= '0;
                    cpu_rst <= 1'b1;
                    running <= 1'b0;
                end
            endcase
        end
    end

`ifdef SIM_RUN_CTRL_UART_TAP_EN
    logic uart_hit_c;

    assign uart_hit_c = (state == S_RUN) && mem_wr && (mem_a == UART_ADDR);

    // UART TX tap: one-cycle strobe per write, byte held between strobes, saturating count.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            uart_valid <= 1'b0;
            uart_byte  <= '0;
            uart_cnt   <= '0;
        end else begin
            uart_valid <= 1'b0;
            if (uart_hit_c) begin
                uart_valid <= 1'b1;
                uart_byte  <= mem_dout;
                if (uart_cnt != 16'hFFFF) begin
                    uart_cnt <= uart_cnt + 16'd1;
                end
            end
        end
    end
`else
    // UART tap compiled out: outputs tied low.
    assign uart_valid = 1'b0;
    assign uart_byte  = 8'h00;
    assign uart_cnt   = 16'h0000;
`endif

endmodule

// File: tb/tb_sim_run_ctrl.sv
// Testbench for sim_run_ctrl: three instances (MAX_CYCLES 500, 0, 10) share one
// stimulus stream; each is compared every cycle against an event-level reference model.
module tb_sim_run_ctrl;

    localparam int unsigned NI      = 3;
    localparam int unsigned RST_C   = 25;
    localparam logic [31:0] HALT_A  = 32'h30004;
    localparam logic [31:0] UART_A  = 32'h30000;

    function automatic int unsigned max_of(input int unsigned i);
        return (i == 0) ? 500 : ((i == 1) ? 0 : 10);
    endfunction

    logic        clk = 1'b0;
    logic        rst_in;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic [7:0]  mem_dout;

    logic [NI-1:0] cpu_rst_w, running_w, done_w, timeout_w, uv_w;
    logic [7:0]    exit_w [NI];
    logic [31:0]   cyc_w  [NI];
    logic [7:0]    ub_w   [NI];
    logic [15:0]   uc_w   [NI];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        sim_run_ctrl #(
            .RST_CYCLES (RST_C),
            .MAX_CYCLES (max_of(g)),
            .CNT_WIDTH  (32),
            .ADDR_WIDTH (32),
            .HALT_ADDR  (HALT_A),
            .UART_ADDR  (UART_A)
        ) u_dut (
            .clk_in     (clk),
            .rst_in     (rst_in),
            .mem_a      (mem_a),
            .mem_wr     (mem_wr),
            .mem_dout   (mem_dout),
            .cpu_rst    (cpu_rst_w[g]),
            .running    (running_w[g]),
            .done       (done_w[g]),
            .timeout    (timeout_w[g]),
            .exit_code  (exit_w[g]),
            .cycle_cnt  (cyc_w[g]),
            .uart_valid (uv_w[g]),
            .uart_byte  (ub_w[g]),
            .uart_cnt   (uc_w[g])
        );
    end

    // Reference model: phase 0=reset seq, 1=run, 2=done, 3=timeout.
    int          ph  [NI];
    int          fell[NI];
    logic [31:0] cyc [NI];
    logic [7:0]  ex  [NI];
    logic        uv  [NI];
    logic [7:0]  ub  [NI];
    int          uc  [NI];

    int total = 0;
    int bad   = 0;
    int stepno = 0;

    task automatic check_val(input string tag, input logic [31:0] o, input logic [31:0] e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    task automatic model_edge(input int i, input logic r, input logic [31:0] a,
                              input logic w, input logic [7:0] d);
        uv[i] = 1'b0;
        if (r) begin
            ph[i] = 0; fell[i] = 0; cyc[i] = '0; ex[i] = '0;
            ub[i] = '0; uc[i] = 0;
        end else if (ph[i] == 0) begin
            // count edges since reset released; core released on the RST_C-th one
            fell[i]++;
            if (fell[i] == RST_C) ph[i] = 1;
        end else if (ph[i] == 1) begin
            cyc[i] = cyc[i] + 32'd1;
`ifdef SIM_RUN_CTRL_UART_TAP_EN
            if (w && a == UART_A) begin
                uv[i] = 1'b1; ub[i] = d;
                if (uc[i] < 65535) uc[i]++;
            end
`endif
            if (w && a == HALT_A) begin
                ph[i] = 2; ex[i] = d;
            end else if (max_of(i) != 0 && cyc[i] == max_of(i)) begin
                ph[i] = 3;
            end
        end
    endtask

    task automatic step(input logic r, input logic [31:0] a, input logic w, input logic [7:0] d);
        logic [68:0] obs, exp;
        rst_in = r; mem_a = a; mem_wr = w; mem_dout = d;
        @(posedge clk);
        for (int i = 0; i < NI; i++) model_edge(i, r, a, w, d);
        #1;
        stepno++;
        for (int i = 0; i < NI; i++) begin
            obs = {cpu_rst_w[i], running_w[i], done_w[i], timeout_w[i], exit_w[i],
                   cyc_w[i], uv_w[i], ub_w[i], uc_w[i]};
            exp = {(ph[i] != 1), (ph[i] == 1), (ph[i] == 2), (ph[i] == 3), ex[i],
                   cyc[i], uv[i], ub[i], 16'(uc[i])};
            total++;
            assert (obs === exp) else begin
                bad++;
                $error("FAIL outputs inst%0d step%0d observed=%h expected=%h", i, stepno, obs, exp);
            end
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 32'h0, 1'b0, 8'h00);
    endtask

    // Release reset and return how many edges it took for instance 0 to start running.
    task automatic release_rst(output int n);
        n = 0;
        do begin
            step(1'b0, 32'h0, 1'b0, 8'h00);
            n++;
        end while (!running_w[0] && n < 40);
    endtask

    initial begin
        int n;
        rst_in = 1'b1; mem_a = '0; mem_wr = 1'b0; mem_dout = '0;
        for (int i = 0; i < NI; i++) begin
            ph[i] = 0; fell[i] = 0; cyc[i] = '0; ex[i] = '0; uv[i] = 1'b0; ub[i] = '0; uc[i] = 0;
        end

        // 1: reset length and first RUN cycle
        repeat (3) step(1'b1, 32'h0, 1'b0, 8'h00);
        check_val("rst_cpu_rst", 32'(cpu_rst_w[0]), 32'd1);
        release_rst(n);
        check_val("rst_len", 32'(n), 32'd25);
        check_val("run_first_cnt", cyc_w[0], 32'd0);

        // 2: halt after 40 cycles
        idle(40);
        step(1'b0, HALT_A, 1'b1, 8'h2A);
        check_val("halt_done", 32'(done_w[0]), 32'd1);
        check_val("halt_exit", 32'(exit_w[0]), 32'h2A);
        check_val("halt_cnt", cyc_w[0], 32'd41);
        step(1'b0, HALT_A, 1'b1, 8'h55);
        idle(3);
        check_val("done_frozen_cnt", cyc_w[0], 32'd41);
        check_val("done_frozen_exit", 32'(exit_w[0]), 32'h2A);

        // 5a + 3: reset from DONE, then watchdog with no halt
        repeat (2) step(1'b1, 32'h0, 1'b0, 8'h00);
        check_val("rst_from_done", 32'(done_w[0]), 32'd0);
        release_rst(n);
        check_val("rst_len2", 32'(n), 32'd25);
        idle(500);
        check_val("wdog_to", 32'(timeout_w[0]), 32'd1);
        check_val("wdog_cnt", cyc_w[0], 32'd500);
        check_val("wdog_done", 32'(done_w[0]), 32'd0);
        idle(1500);
        check_val("wdog_off_to", 32'(timeout_w[1]), 32'd0);
        check_val("wdog_off_cnt", cyc_w[1], 32'd2000);

        // 4: halt on the cycle the 10-cycle watchdog would expire
        step(1'b1, 32'h0, 1'b0, 8'h00);
        release_rst(n);
        idle(9);
        step(1'b0, HALT_A, 1'b1, 8'h07);
        check_val("tie_done", 32'(done_w[2]), 32'd1);
        check_val("tie_to", 32'(timeout_w[2]), 32'd0);
        check_val("tie_cnt", cyc_w[2], 32'd10);

        // 5b: reset mid-RUN, then reads of the halt address
        step(1'b1, 32'h0, 1'b0, 8'h00);
        release_rst(n);
        idle(30);
        repeat (2) step(1'b1, 32'h0, 1'b0, 8'h00);
        check_val("midrun_rst_cnt", cyc_w[0], 32'd0);
        check_val("midrun_rst_cpu", 32'(cpu_rst_w[0]), 32'd1);
        release_rst(n);
        check_val("rst_len3", 32'(n), 32'd25);
        for (int k = 0; k < 5; k++) step(1'b0, HALT_A, 1'b0, 8'hEE);
        check_val("read_no_halt", 32'(done_w[0]), 32'd0);

        // 6: UART tap
        step(1'b0, UART_A, 1'b1, 8'h48);
        step(1'b0, UART_A, 1'b1, 8'h69);
        step(1'b0, 32'h0, 1'b0, 8'h00);
`ifdef SIM_RUN_CTRL_UART_TAP_EN
        check_val("uart_cnt", 32'(uc_w[0]), 32'd2);
        check_val("uart_byte", 32'(ub_w[0]), 32'h69);
`else
        check_val("uart_cnt_off", 32'(uc_w[0]), 32'd0);
        check_val("uart_byte_off", 32'(ub_w[0]), 32'h0);
`endif

        // Randomized episodes against the model
        for (int e = 0; e < 8; e++) begin
            int len;
            repeat ($urandom_range(1, 4)) step(1'b1, 32'h0, 1'b0, 8'h00);
            len = int'($urandom_range(50, 650));
            for (int k = 0; k < len; k++) begin
                int unsigned r;
                logic [7:0] d;
                r = $urandom_range(0, 999);
                d = 8'($urandom);
                if (r < 2)        step(1'b1, 32'h0, 1'b0, d);
                else if (r < 5)   step(1'b0, HALT_A, 1'b1, d);
                else if (r < 80)  step(1'b0, UART_A, 1'b1, d);
                else if (r < 140) step(1'b0, HALT_A, 1'b0, d);
                else if (r < 300) step(1'b0, $urandom, 1'b1, d);
                else if (r < 320) step(1'b0, HALT_A ^ (32'd1 << $urandom_range(0, 31)), 1'b1, d);
                else              step(1'b0, $urandom, 1'b0, d);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
